pipe_skid_buffer: RTL and testbench
===================================

PIPE_SKID_BUFFER -- requirements
Module: pipe_skid_buffer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the payload width in bits.
REQ-002 The module SHALL have port clk  input  1  rising-edge clock.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The module SHALL have port in_valid  input  1  upstream data valid.
REQ-005 The module SHALL have port in_data  input  WIDTH  upstream payload.
REQ-006 The module SHALL have port in_ready  output  1  buffer can accept a word this cycle.
REQ-007 The module SHALL have port out_valid  output  1  out_data holds a valid word.
REQ-008 The module SHALL have port out_data  output  WIDTH  downstream payload.
REQ-009 The module SHALL have port out_ready  input  1  downstream accepts a word this cycle.
REQ-010 The module SHALL have port occupancy  output  2  number of words held, 0..2.

Function
REQ-011 A transfer SHALL occur on a rising clk edge when valid and ready are both high on the same side; no transfer occurs otherwise.
REQ-012 Storage SHALL be a main register (drives out_data) and a skid register, each with its own valid bit.
REQ-013 The FSM SHALL have states EMPTY (occupancy 0), BUSY (main full, occupancy 1) and FULL (main and skid full, occupancy 2).
REQ-014 in_ready SHALL be a registered output, high in EMPTY and BUSY and low in FULL; it SHALL NOT combinationally depend on out_ready.
REQ-015 out_valid SHALL be high in BUSY and FULL and low in EMPTY.
REQ-016 EMPTY: in transfer -> main <= in_data, go BUSY; else stay.
REQ-017 BUSY: in and out transfer together -> main <= in_data, stay BUSY; out only -> go EMPTY; in only -> skid <= in_data, go FULL; neither -> stay.
REQ-018 FULL: out transfer -> main <= skid, go BUSY; else stay; in_valid is ignored.
REQ-019 Latency from in transfer to out_valid SHALL be 1 cycle when EMPTY; sustained throughput SHALL be 1 word/cycle while out_ready stays high.
REQ-020 Words SHALL exit in exactly the order accepted, with no loss or duplication.
REQ-021 out_data SHALL remain stable while out_valid is high and out_ready is low.
REQ-022 Registers SHALL NOT load when no transfer occurs; X on in_data with in_valid low SHALL NOT propagate.

Reset
REQ-023 rst high SHALL immediately force state EMPTY, out_valid 0, in_ready 0, occupancy 0, and main/skid data and valid bits 0.
REQ-024 in_ready SHALL go high on the first rising clk edge after rst deasserts.
REQ-025 rst asserted mid-operation SHALL discard all held words; no word accepted before reset SHALL appear after it.

Structure
REQ-026 WIDTH default and the FSM state encoding (EMPTY=2'b00, BUSY=2'b01, FULL=2'b10) SHALL be defined in shared package pipe_pkg.
REQ-027 The main and skid storage SHALL each instantiate sub-module skid_data_reg (WIDTH-bit register with async reset and load enable).
REQ-028 Encoding 2'b11 SHALL be unreachable and SHALL recover to EMPTY on the next clock.

Verification
REQ-029 Reset then one word: rst pulse, in_valid=1 in_data=8'hA5 one cycle, out_ready=1 -> out_valid high next cycle with 8'hA5, then EMPTY.
REQ-030 Streaming: 16 words 8'h00..8'h0F back-to-back, out_ready=1 -> 16 outputs in order, in_ready never low, occupancy never 2.
REQ-031 Stall fill: out_ready=0, offer 8'h11, 8'h22, 8'h33 -> 8'h11 and 8'h22 accepted, in_ready low, occupancy 2, 8'h33 held upstream; raise out_ready -> 8'h11, 8'h22, 8'h33 exit in order.
REQ-032 Stability: out_ready=0 for 5 cycles with out_valid=1 and in_data toggling -> out_data constant.
REQ-033 Reset mid-operation: FULL with 8'h44/8'h55, assert rst -> out_valid 0 and occupancy 0 immediately; after release, neither 8'h44 nor 8'h55 appears.
REQ-034 Random valid/ready at 50 % each over 10000 cycles -> scoreboard shows no loss, no duplication, order preserved.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline skid buffer: default payload width and FSM encoding.
package pipe_pkg;

   localparam int unsigned WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      StEmpty = 2'b00,
      StBusy  = 2'b01,
      StFull  = 2'b10
   } state_e;

endpackage

// File: rtl/skid_data_reg.sv
// Payload register with asynchronous active-high reset and load enable.
module skid_data_reg #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q <= '0;
      end else if (i_load) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry skid buffer: registered in_ready, main register drives out_data, skid absorbs
// the word accepted in the cycle downstream stalls.
module pipe_skid_buffer
   import pipe_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       occupancy
);

   state_e           r_state;
   state_e           w_state_d;
   logic             r_in_ready;
   logic             r_main_valid;
   logic             r_skid_valid;
   logic             w_in_xfer;
   logic             w_out_xfer;
   logic             w_main_load;
   logic             w_main_from_skid;
   logic             w_skid_load;
   logic [WIDTH-1:0] w_main_d;
   logic [WIDTH-1:0] w_main_q;
   logic [WIDTH-1:0] w_skid_q;

   assign w_in_xfer  = in_valid & r_in_ready;
   assign w_out_xfer = out_valid & out_ready;

   // State register; in_ready and valid bits are registered from the next state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= StEmpty;
         r_in_ready   <= 1'b0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else begin
         r_state      <= w_state_d;
         r_in_ready   <= (w_state_d != StFull);
         r_main_valid <= (w_state_d != StEmpty);
         r_skid_valid <= (w_state_d == StFull);
      end
   end

   always_comb begin
      w_state_d        = r_state;
      w_main_load      = 1'b0;
      w_main_from_skid = 1'b0;
      w_skid_load      = 1'b0;
      case (r_state)
         StEmpty: begin
            if (w_in_xfer) begin
               w_main_load = 1'b1;
               w_state_d   = StBusy;
            end
         end
         StBusy: begin
            if (w_in_xfer && w_out_xfer) begin
               w_main_load = 1'b1;
            end else if (w_out_xfer) begin
               w_state_d = StEmpty;
            end else if (w_in_xfer) begin
               w_skid_load = 1'b1;
               w_state_d   = StFull;
            end
         end
         StFull: begin
            if (w_out_xfer) begin
               w_main_load      = 1'b1;
               w_main_from_skid = 1'b1;
               w_state_d        = StBusy;
            end
         end
         default: begin
            // Unreachable encoding 2'b11 falls back to empty without loading anything.
            w_state_d = StEmpty;
         end
      endcase
   end

   always_comb begin
      in_ready  = r_in_ready;
      out_valid = r_main_valid;
      occupancy = {r_skid_valid, r_main_valid & ~r_skid_valid};
   end

   assign w_main_d = w_main_from_skid ? w_skid_q : in_data;

   skid_data_reg #(
      .WIDTH (WIDTH)
   ) u_main_reg (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_main_load),
      .i_d    (w_main_d),
      .o_q    (w_main_q)
   );

   skid_data_reg #(
      .WIDTH (WIDTH)
   ) u_skid_reg (
      .clk    (clk),
      .rst    (rst),
      .i_load (w_skid_load),
      .i_d    (in_data),
      .o_q    (w_skid_q)
   );

   assign out_data = w_main_q;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Bench for pipe_skid_buffer: queue-based reference model compared every cycle, plus directed
// scenarios with literal expectations and a long random valid/ready run.
module tb_pipe_skid_buffer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] in_data = 8'h00;
   logic       in_ready;
   logic       out_valid;
   logic [7:0] out_data;
   logic       out_ready = 1'b0;
   logic [1:0] occupancy;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: FIFO of accepted words, capacity two, ready only after first clean edge.
   logic [7:0] mq[$];
   bit         m_rdy = 1'b0;
   int         m_acc = 0;
   logic [7:0] got[$];

   always #5 clk = ~clk;

   pipe_skid_buffer #(
      .WIDTH (8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .occupancy (occupancy)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mq.delete();
            m_rdy = 1'b0;
         end else begin
            bit in_x;
            bit out_x;
            in_x  = in_valid && m_rdy && (mq.size() < 2);
            out_x = (mq.size() > 0) && out_ready;
            if (out_x) void'(mq.pop_front());
            if (in_x) begin
               mq.push_back(in_data);
               m_acc++;
            end
            m_rdy = 1'b1;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         check("in_ready", {31'd0, in_ready}, {31'd0, m_rdy && (mq.size() < 2)});
         check("out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
         check("occupancy", {30'd0, occupancy}, mq.size());
         if (mq.size() > 0) check("out_data", {24'd0, out_data}, {24'd0, mq[0]});
         if (out_valid && out_ready) got.push_back(out_data);
      end
   end

   initial begin
      // Reset, then a single word.
      repeat (3) tick();
      rst = 1'b0;
      tick();
      check("rdy_after_reset", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      tick();
      check("one_valid", {31'd0, out_valid}, 32'd1);
      check("one_data", {24'd0, out_data}, 32'hA5);
      check("one_occ", {30'd0, occupancy}, 32'd1);
      in_valid = 1'b0;
      tick();
      check("one_empty_valid", {31'd0, out_valid}, 32'd0);
      check("one_empty_occ", {30'd0, occupancy}, 32'd0);

      // Streaming at full rate.
      got.delete();
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         in_data = 8'(i);
         tick();
         check("stream_rdy", {31'd0, in_ready}, 32'd1);
         check("stream_occ", {30'd0, occupancy}, 32'd1);
      end
      in_valid = 1'b0;
      tick(); tick();
      check("stream_count", got.size(), 32'd16);
      for (int i = 0; i < 16 && i < got.size(); i++) check("stream_order", {24'd0, got[i]}, i);

      // Stall fill.
      got.delete();
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h11;
      tick();
      in_data = 8'h22;
      tick();
      check("fill_occ", {30'd0, occupancy}, 32'd2);
      check("fill_rdy", {31'd0, in_ready}, 32'd0);
      in_data = 8'h33;
      tick();
      check("fill_hold_occ", {30'd0, occupancy}, 32'd2);
      check("fill_hold_rdy", {31'd0, in_ready}, 32'd0);
      check("fill_head", {24'd0, out_data}, 32'h11);
      out_ready = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      tick(); tick();
      check("fill_count", got.size(), 32'd3);
      if (got.size() == 3) begin
         check("fill_w0", {24'd0, got[0]}, 32'h11);
         check("fill_w1", {24'd0, got[1]}, 32'h22);
         check("fill_w2", {24'd0, got[2]}, 32'h33);
      end

      // Output stability under stall with in_data toggling.
      in_valid = 1'b1; in_data = 8'h77; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         in_data = 8'($urandom);
         tick();
         check("stable_valid", {31'd0, out_valid}, 32'd1);
         check("stable_data", {24'd0, out_data}, 32'h77);
      end
      out_ready = 1'b1;
      tick(); tick();

      // Reset while full.
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h44;
      tick();
      in_data = 8'h55;
      tick();
      in_valid = 1'b0;
      check("pre_rst_occ", {30'd0, occupancy}, 32'd2);
      rst = 1'b1;
      #1;
      check("rst_valid", {31'd0, out_valid}, 32'd0);
      check("rst_occ", {30'd0, occupancy}, 32'd0);
      check("rst_rdy", {31'd0, in_ready}, 32'd0);
      tick();
      rst = 1'b0;
      got.delete();
      in_valid = 1'b1; in_data = 8'h66; out_ready = 1'b1;
      tick(); tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      check("post_rst_count", got.size(), 32'd1);
      if (got.size() > 0) check("post_rst_word", {24'd0, got[0]}, 32'h66);
      begin
         bit stale = 1'b0;
         for (int i = 0; i < got.size(); i++)
            if (got[i] == 8'h44 || got[i] == 8'h55) stale = 1'b1;
         check("no_stale", {31'd0, stale}, 32'd0);
      end

      // Random valid/ready at 50 %.
      got.delete();
      m_acc = 0;
      for (int i = 0; i < 10000; i++) begin
         in_valid  = 1'($urandom_range(0, 1));
         in_data   = 8'($urandom);
         out_ready = 1'($urandom_range(0, 1));
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      repeat (4) tick();
      check("random_drained", got.size(), m_acc);
      check("random_empty", {30'd0, occupancy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
